// File: rtl/btn_pkg.sv
// Shared types and default parameters for the button conditioner.
// BTN_AUTOREPEAT_EN enables held-button auto-repeat pulses.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_REPEAT_DELAY    = 50000;
    localparam int DEF_REPEAT_PERIOD   = 10000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce FSM, optional repeat timer.
// Auto-repeat logic exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    btn_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    btn_state_t             w_state_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_level_nxt;
    logic                   w_press_nxt;
    logic                   w_release_nxt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RCW-1:0] RPT_FIRST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RPT_NEXT  = RCW'(REPEAT_PERIOD - 1);
    localparam logic [RCW-1:0] RPT_ONE   = RCW'(1);

    // r_rpt_first selects the initial delay versus the steady period
    logic [RCW-1:0] r_rpt_cnt;
    logic           r_rpt_first;
    logic [RCW-1:0] w_rpt_cnt_nxt;
    logic           w_rpt_first_nxt;
    logic [RCW-1:0] w_rpt_tgt;

    assign w_rpt_tgt = r_rpt_first ? RPT_FIRST : RPT_NEXT;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_first <= w_rpt_first_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync    <= '0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_rpt_first_nxt = r_rpt_first;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    w_rpt_cnt_nxt   = '0;
                    w_rpt_first_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!w_s) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
`ifdef BTN_AUTOREPEAT_EN
                    w_rpt_cnt_nxt = '0;
                end else if (r_rpt_cnt == w_rpt_tgt) begin
                    w_press_nxt     = 1'b1;
                    w_rpt_cnt_nxt   = '0;
                    w_rpt_first_nxt = 1'b0;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RPT_ONE;
`endif
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
`ifdef BTN_AUTOREPEAT_EN
                    w_rpt_cnt_nxt   = '0;
                    w_rpt_first_nxt = 1'b1;
`endif
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == ST_HELD) ||
                      (w_state_nxt == ST_RELEASE_WAIT);
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button debouncer with press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("button_conditioner: N_CH out of range");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_btn     (btn_in[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: run-length reference model vs button_conditioner.
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_CH            (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level   (lvl),
        .btn_press   (prs),
        .btn_release (rel)
    );

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] hist[$];
    int           vectors = 0;
    int           errs    = 0;
    int           cyc     = 0;
    int           m_run[N];
    int           m_age[N];
    bit           m_lvl[N];

    // Model: level flips after D+1 consecutive disagreeing samples of the
    // input delayed by S edges; repeat timing counts edges of stable hold.
    always @(posedge clk) begin
        exp_t         e;
        logic [N-1:0] s;
        int           rb;
        cyc++;
        e = '0;
        if (!reset_n) begin
            hist = {};
            for (int k = 0; k < S; k++) hist.push_back('0);
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
                m_lvl[i] = 1'b0;
            end
        end else begin
            s = hist.pop_front();
            hist.push_back(btn_in);
            for (int i = 0; i < N; i++) begin
                rb = m_run[i];
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                        m_age[i] = 0;
                        if (m_lvl[i]) e.prs[i] = 1'b1;
                        else e.rel[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                    if (AR && m_lvl[i]) begin
                        if (rb > 0) m_age[i] = 0;
                        else begin
                            m_age[i]++;
                            if (m_age[i] == RD ||
                                (m_age[i] > RD &&
                                 (m_age[i] - RD) % RP == 0))
                                e.prs[i] = 1'b1;
                        end
                    end
                end
                e.lvl[i] = m_lvl[i];
            end
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            errs++;
            $display("FAIL scoreboard_empty cyc=%0d", cyc);
        end else begin
            e = q.pop_front();
            if ({lvl, prs, rel} !== e) begin
                errs++;
                $display("FAIL out cyc=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b",
                         cyc, lvl, prs, rel, e.lvl, e.prs, e.rel);
            end
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%b exp=%b", nm, act, exp);
        end
    endtask

    // Caller changes btn_in at a negedge; the next posedge is edge t.
    task automatic lat(input logic [N-1:0] m, input bit press,
                       input string nm);
        @(posedge clk);
        repeat (S + D - 1) @(posedge clk);
        #1;
        chk({nm, "_early_pulse"}, press ? (prs & m) : (rel & m), '0);
        chk({nm, "_early_lvl"}, lvl & m, press ? '0 : m);
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, press ? (prs & m) : (rel & m), m);
        chk({nm, "_other"}, press ? (rel & m) : (prs & m), '0);
        chk({nm, "_lvl"}, lvl & m, press ? m : '0);
    endtask

    initial begin
        int hold[N];
        reset_n = 1'b0;
        btn_in  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        btn_in = 2'b01;
        lat(2'b01, 1'b1, "press0");
        repeat (14) @(negedge clk);
        btn_in = 2'b00;
        repeat (2) @(negedge clk);
        btn_in = 2'b01;
        @(negedge clk);
        btn_in = 2'b00;
        lat(2'b01, 1'b0, "release0");
        repeat (6) @(negedge clk);

        btn_in = 2'b01;
        repeat (3) @(negedge clk);
        btn_in = 2'b00;
        repeat (12) @(negedge clk);
        chk("short_pulse_lvl", lvl, '0);

        btn_in = 2'b01;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {lvl, prs, rel}, '0);
        reset_n = 1'b1;
        lat(2'b01, 1'b1, "held_reset");
        @(negedge clk);
        btn_in = 2'b00;
        repeat (12) @(negedge clk);

        btn_in = 2'b11;
        lat(2'b11, 1'b1, "both");
        repeat (30) @(negedge clk);
        btn_in = 2'b00;
        lat(2'b11, 1'b0, "both_rel");
        @(negedge clk);

        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_in[i] = ~btn_in[i];
                    hold[i] = ($urandom_range(0, 4) == 0) ?
                              $urandom_range(15, 40) :
                              $urandom_range(1, 8);
                end
            end
            reset_n = ($urandom_range(0, 299) != 0);
        end
        reset_n = 1'b1;
        btn_in  = '0;
        repeat (20) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
